// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter: FSM encodings and default frame width.
package serial_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; the MSB of the register is the serial output.
module piso_shift_reg
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic              sout
);

    logic [DATA_W-1:0] sr_r;

    // Load has priority so a back-to-back frame replaces the tail of the old one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_r <= {DATA_W{1'b0}};
        end else if (load) begin
            sr_r <= din;
        end else if (clr) begin
            sr_r <= {DATA_W{1'b0}};
        end else if (shift) begin
            sr_r <= {sr_r[DATA_W-2:0], 1'b0};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign sout = sr_r[DATA_W-1];

endmodule

// File: rtl/serial_frame_transmitter.sv
// Serialises a DATA_W-bit word MSB first with framing, busy and end-of-frame strobes.
module serial_frame_transmitter
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sframe,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PENULT_C = CNT_W'(DATA_W - 2);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sframe_r;
    logic             busy_r;
    logic             done_r;
    logic             last_s;
    logic             accept_s;
    logic             shift_s;
    logic             clr_s;

    // The last-bit cycle is the only SHIFT cycle that can take a new word.
    assign last_s    = (state_r == SHIFT) && (cnt_r == LAST_C);
    assign din_ready = (state_r == IDLE) || last_s;
    assign accept_s  = din_valid && din_ready;
    assign shift_s   = (state_r == SHIFT) && !last_s;
    assign clr_s     = last_s && !accept_s;

    // FSM, bit counter and registered framing outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            sframe_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r  <= {CNT_W{1'b0}};
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r  <= SHIFT;
                        sframe_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        sframe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last_s) begin
                        cnt_r  <= {CNT_W{1'b0}};
                        done_r <= 1'b0;
                        if (accept_s) begin
                            state_r  <= SHIFT;
                            sframe_r <= 1'b1;
                            busy_r   <= 1'b1;
                        end else begin
                            state_r  <= IDLE;
                            sframe_r <= 1'b0;
                            busy_r   <= 1'b0;
                        end
                    end else begin
                        state_r  <= SHIFT;
                        cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        sframe_r <= 1'b1;
                        busy_r   <= 1'b1;
                        done_r   <= (cnt_r == PENULT_C);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= {CNT_W{1'b0}};
                    sframe_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    piso_shift_reg #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_s),
        .shift (shift_s),
        .clr   (clr_s),
        .din   (din),
        .sout  (sout)
    );

    assign sframe = sframe_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Scoreboard bench: stimulus pushes expected {sout,done} per bit, monitors pop and compare.
module tb_serial_frame_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din8;
    logic       v8;
    logic       rdy8, sout8, sframe8, busy8, done8;
    logic [1:0] din2;
    logic       v2;
    logic       rdy2, sout2, sframe2, busy2, done2;

    int checks = 0;
    int errors = 0;
    logic [1:0] q8[$];
    logic [1:0] q2[$];
    int run8 = 0;
    int last_run8 = 0;
    int run2 = 0;
    int last_run2 = 0;

    always #5 clk = ~clk;

    serial_frame_transmitter #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .din(din8), .din_valid(v8), .din_ready(rdy8),
        .sout(sout8), .sframe(sframe8), .busy(busy8), .done(done8)
    );

    serial_frame_transmitter #(.DATA_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(v2), .din_ready(rdy2),
        .sout(sout2), .sframe(sframe2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            if (sframe8) begin
                if (q8.size() == 0) begin
                    bad("dut8 unexpected bit");
                end else begin
                    e = q8.pop_front();
                    chk("dut8 sout", {31'd0, sout8}, {31'd0, e[1]});
                    chk("dut8 done", {31'd0, done8}, {31'd0, e[0]});
                    chk("dut8 busy", {31'd0, busy8}, 32'd1);
                end
                run8++;
            end else begin
                chk("dut8 idle outputs", {29'd0, sout8, busy8, done8}, 32'd0);
                if (run8 != 0) last_run8 = run8;
                run8 = 0;
            end
        end else begin
            run8 = 0;
        end
    end

    // Monitor for the 2-bit instance.
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            if (sframe2) begin
                if (q2.size() == 0) begin
                    bad("dut2 unexpected bit");
                end else begin
                    e = q2.pop_front();
                    chk("dut2 sout", {31'd0, sout2}, {31'd0, e[1]});
                    chk("dut2 done", {31'd0, done2}, {31'd0, e[0]});
                    chk("dut2 busy", {31'd0, busy2}, 32'd1);
                end
                run2++;
            end else begin
                chk("dut2 idle outputs", {29'd0, sout2, busy2, done2}, 32'd0);
                if (run2 != 0) last_run2 = run2;
                run2 = 0;
            end
        end else begin
            run2 = 0;
        end
    end

    task automatic push8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) q8.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
    endtask

    // Present w at a negedge where din_ready is high so it is taken at the next posedge.
    task automatic send8(input logic [7:0] w);
        int t = 0;
        @(negedge clk);
        while (!rdy8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            bad("dut8 din_ready timeout");
        end else begin
            din8 = w;
            v8 = 1'b1;
            push8(w);
            @(posedge clk);
            #1 v8 = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; din8 = 8'h00; v8 = 1'b0; din2 = 2'b00; v2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset sframe", {31'd0, sframe8}, 32'd0);
        chk("reset outputs", {29'd0, sout8, busy8, done8}, 32'd0);
        rst = 1'b1;
        #1;
        chk("reset din_ready", {31'd0, rdy8}, 32'd1);
        idle(2);

        // Single frame.
        send8(8'hA5);
        idle(12);
        chk("single frame length", last_run8, 32'd8);

        // Back-to-back with the second word taken in the last-bit cycle.
        send8(8'hFF);
        send8(8'h00);
        idle(20);
        chk("back-to-back length", last_run8, 32'd16);

        // Blocked request mid-frame, then accepted in the last-bit cycle.
        send8(8'h96);
        repeat (3) @(negedge clk);
        din8 = 8'h3C;
        v8 = 1'b1;
        chk("blocked din_ready", {31'd0, rdy8}, 32'd0);
        begin
            int t = 0;
            while (!rdy8 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) bad("blocked accept timeout");
            else chk("blocked accept at bit 8", t, 32'd5);
        end
        push8(8'h3C);
        @(posedge clk);
        #1 v8 = 1'b0;
        idle(20);
        chk("blocked then next length", last_run8, 32'd16);

        // Reset on the 4th bit of 8'hC3.
        send8(8'hC3);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        v8 = 1'b1;
        q8.delete();
        @(posedge clk);
        #1;
        chk("abort sframe", {31'd0, sframe8}, 32'd0);
        chk("abort outputs", {29'd0, sout8, busy8, done8}, 32'd0);
        @(posedge clk);
        #1;
        chk("valid ignored in reset", {31'd0, sframe8}, 32'd0);
        v8 = 1'b0;
        rst = 1'b1;
        idle(12);
        chk("no bits after abort", {31'd0, sframe8}, 32'd0);

        // Din changes after capture.
        send8(8'h81);
        din8 = 8'h7E;
        idle(12);
        chk("din change length", last_run8, 32'd8);

        // Two-bit instance.
        begin
            int t = 0;
            @(negedge clk);
            while (!rdy2 && t < 20) begin
                @(negedge clk);
                t++;
            end
            din2 = 2'b10;
            v2 = 1'b1;
            q2.push_back(2'b10);
            q2.push_back(2'b01);
            @(posedge clk);
            #1 v2 = 1'b0;
        end
        idle(6);
        chk("width2 length", last_run2, 32'd2);

        idle(4);
        chk("dut8 queue drained", q8.size(), 32'd0);
        chk("dut2 queue drained", q2.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_transmitter.md
SERIAL_FRAME_TRANSMITTER -- requirements
Module: serial_frame_transmitter

Interface
REQ-001 SHALL have parameter: DATA_W, 8, frame width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all registers update on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: din  input  DATA_W  parallel word to transmit.
REQ-005 SHALL have port: din_valid  input  1  din holds a word to send.
REQ-006 SHALL have port: din_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: sout  output  1  serial data, MSB first.
REQ-008 SHALL have port: sframe  output  1  high in every cycle where sout carries a valid bit.
REQ-009 SHALL have port: busy  output  1  a frame is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse aligned with the last bit of a frame.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 SHALL accept a word on any rising edge where din_valid=1 and din_ready=1; this is the only capture condition.
REQ-013 SHALL ignore din_valid while din_ready=0; no capture, and no state or output change from it.
REQ-014 SHALL drive din_ready=1 in IDLE, and in SHIFT only during the last-bit cycle; din_ready SHALL be 0 at all other times.
REQ-015 On acceptance from IDLE, SHALL enter SHIFT and place din[DATA_W-1] on sout in the next cycle (latency 1 cycle).
REQ-016 SHALL emit one bit per cycle, MSB to LSB, for exactly DATA_W consecutive cycles, with sframe=1 and busy=1 throughout.
REQ-017 SHALL count bits with a counter of width ceil(log2(DATA_W)) that counts 0..DATA_W-1 and returns to 0 at the end of each frame.
REQ-018 SHALL assert done=1 only in the cycle where sout carries bit 0.
REQ-019 On acceptance in the last-bit cycle, SHALL start the next frame's MSB in the following cycle, with no gap and sframe held at 1.
REQ-020 With no acceptance in the last-bit cycle, SHALL return to IDLE, where sout=0, sframe=0, busy=0 and done=0.
REQ-021 SHALL ignore changes on din after capture; the frame SHALL transmit the captured value.
REQ-022 SHALL produce sout, sframe, busy and done directly from registers.

Reset
REQ-023 When rst=0 at a rising edge, the next state SHALL be IDLE, with counter=0, shift register=0, sout=0, sframe=0, busy=0, done=0 and din_ready=1 after release.
REQ-024 Reset mid-frame SHALL abort the frame immediately; no further bits of that frame SHALL appear after release.
REQ-025 While rst=0, SHALL ignore din_valid.

Structure
REQ-026 SHALL place the FSM state encodings (IDLE=0, SHIFT=1) and the DATA_W default in the shared package serial_pkg.
REQ-027 SHALL implement the shift register and load logic as one sub-module, piso_shift_reg; the FSM and bit counter SHALL stay in the top module.

Verification
REQ-028 Single frame: DATA_W=8, accept din=8'hA5 -> sout=1,0,1,0,0,1,0,1 on the 8 cycles after acceptance, sframe=1 for those 8 cycles, done on the 8th cycle, IDLE after.
REQ-029 Back-to-back: 8'hFF accepted, then 8'h00 accepted in the last-bit cycle -> 16 continuous sframe cycles, sout=eight 1s then eight 0s, done on cycles 8 and 16.
REQ-030 Blocked request: din_valid=1 with din=8'h3C on cycle 3 of a frame -> no capture and the current frame is unchanged; 8'h3C is accepted in the last-bit cycle and sent next.
REQ-031 Reset mid-frame: rst=0 on the 4th bit of 8'hC3 -> the cycle after the edge shows sout=0, sframe=0, busy=0, done=0; no done pulse.
REQ-032 Din change: accept 8'h81, then change din to 8'h7E the next cycle -> sout=1,0,0,0,0,0,0,1.
REQ-033 Width check: DATA_W=2, accept 2'b10 -> sout=1,0, with done on the 2nd cycle.
